// File: rtl/tl_mem_responder_pkg.sv
// rtl/tl_mem_responder_pkg.sv - TileLink opcodes, field widths and opcode helpers
//
// Shared TileLink-UL definitions for the memory responder slice.
//   `TL_GET / `TL_PUT_FULL / `TL_PUT_PARTIAL : A-channel opcodes
//   `TL_ACCESS_ACK / `TL_ACCESS_ACK_DATA     : D-channel opcodes
// Package: field widths and the supported-opcode check.

`ifndef TL_DEFINES_SVH
`define TL_DEFINES_SVH
`define TL_PUT_FULL        3'd0
`define TL_PUT_PARTIAL     3'd1
`define TL_GET             3'd4
`define TL_ACCESS_ACK      3'd0
`define TL_ACCESS_ACK_DATA 3'd1
`endif

package tl_mem_responder_pkg;

    localparam int unsigned TL_OP_W   = 3;
    localparam int unsigned TL_SZ_W   = 3;
    localparam int unsigned TL_SRC_W  = 4;
    localparam int unsigned TL_DATA_W = 64;
    localparam int unsigned TL_MASK_W = TL_DATA_W / 8;

    function automatic logic tl_is_put(input logic [TL_OP_W-1:0] op);
        return (op == `TL_PUT_FULL) || (op == `TL_PUT_PARTIAL);
    endfunction

    function automatic logic tl_is_supported(input logic [TL_OP_W-1:0] op);
        return tl_is_put(op) || (op == `TL_GET);
    endfunction

endpackage

// File: rtl/tl_mem_responder_if.sv
// rtl/tl_mem_responder_if.sv - TileLink-UL A/D channel bundle
//
// Interface tilelink with modports:
//   slave  : receives A (a_valid, a_opcode, a_size, a_source, a_mask, a_address, a_data),
//            drives a_ready, drives D (d_valid, d_opcode, d_size, d_source, d_data, d_denied),
//            receives d_ready.
//   master : the mirror image.

interface tilelink;
    import tl_mem_responder_pkg::*;

    logic                 a_valid;
    logic                 a_ready;
    logic [TL_OP_W-1:0]   a_opcode;
    logic [TL_SZ_W-1:0]   a_size;
    logic [TL_SRC_W-1:0]  a_source;
    logic [TL_MASK_W-1:0] a_mask;
    logic [63:0]          a_address;
    logic [TL_DATA_W-1:0] a_data;

    logic                 d_valid;
    logic                 d_ready;
    logic [TL_OP_W-1:0]   d_opcode;
    logic [TL_SZ_W-1:0]   d_size;
    logic [TL_SRC_W-1:0]  d_source;
    logic [TL_DATA_W-1:0] d_data;
    logic                 d_denied;

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_mask, a_address, a_data,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        input  d_ready
    );

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_mask, a_address, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        output d_ready
    );

endinterface

// File: rtl/tl_sram.sv
// rtl/tl_sram.sv - DEPTH x 64 memory, synchronous read, byte-masked write
//
// Ports:
//   clk, rst         : clock, async active-high reset (read register only)
//   re, we           : read / write enables
//   addr [AW-1:0]    : word index
//   wmask[7:0]       : byte write enables
//   wdata[63:0]      : write data
//   rdata[63:0]      : registered read data, updated the edge after re

module tl_sram #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wmask,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;
    logic [63:0] rdata_d;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink-UL memory responder, one outstanding access
//
// Parameters: DEPTH (64-bit words), BASE (byte address of word 0), LATENCY (>=1).
// Ports:
//   clk : clock
//   rst : async active-high reset
//   bus : tilelink.slave (A channel in, D channel out)
// Build option: TL_MEM_DENY_EN denies accesses outside [BASE, BASE+8*DEPTH);
// without it addresses wrap modulo DEPTH words.

module tl_mem_responder
    import tl_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    tilelink.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [TL_OP_W-1:0]   op_q, op_d;
    logic [TL_SZ_W-1:0]   size_q, size_d;
    logic [TL_SRC_W-1:0]  src_q, src_d;
    logic [TL_MASK_W-1:0] mask_q, mask_d;
    logic [TL_DATA_W-1:0] data_q, data_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 deny_q, deny_d;
    logic                 a_ready_q, a_ready_d;
    logic                 d_valid_q, d_valid_d;
    logic [TL_OP_W-1:0]   d_opcode_q, d_opcode_d;
    logic [TL_SZ_W-1:0]   d_size_q, d_size_d;
    logic [TL_SRC_W-1:0]  d_source_q, d_source_d;
    logic                 d_denied_q, d_denied_d;
    logic                 rdsel_q, rdsel_d;

    logic                 addr_deny;
    logic                 mem_re;
    logic                 mem_we;
    logic [63:0]          mem_rdata;

`ifdef TL_MEM_DENY_EN
    assign addr_deny = (bus.a_address < BASE) ||
                       (bus.a_address >= BASE + 64'(8 * DEPTH));
`else
    assign addr_deny = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        size_d     = size_q;
        src_d      = src_q;
        mask_d     = mask_q;
        data_d     = data_q;
        idx_d      = idx_q;
        deny_d     = deny_q;
        a_ready_d  = a_ready_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        rdsel_d    = rdsel_q;
        mem_re     = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // a_ready comes up one edge after reset release, then stays
                // high until a request is taken.
                a_ready_d = 1'b1;
                if (bus.a_valid && a_ready_q) begin
                    op_d      = bus.a_opcode;
                    size_d    = bus.a_size;
                    src_d     = bus.a_source;
                    mask_d    = bus.a_mask;
                    data_d    = bus.a_data;
                    // Wrapping 64-bit offset; byte bits [2:0] drop out in the shift.
                    idx_d     = AW'((bus.a_address - BASE) >> 3);
                    deny_d    = !tl_is_supported(bus.a_opcode) || addr_deny;
                    a_ready_d = 1'b0;
                    cnt_d     = 16'(LATENCY - 1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    mem_re     = (op_q == `TL_GET) && !deny_q;
                    mem_we     = tl_is_put(op_q) && !deny_q;
                    d_valid_d  = 1'b1;
                    d_opcode_d = (op_q == `TL_GET) ? `TL_ACCESS_ACK_DATA : `TL_ACCESS_ACK;
                    d_size_d   = size_q;
                    d_source_d = src_q;
                    d_denied_d = deny_q;
                    rdsel_d    = (op_q == `TL_GET) && !deny_q;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RESP: begin
                if (d_valid_q && bus.d_ready) begin
                    d_valid_d = 1'b0;
                    rdsel_d   = 1'b0;
                    a_ready_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            size_q     <= '0;
            src_q      <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            deny_q     <= 1'b0;
            a_ready_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            rdsel_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            size_q     <= size_d;
            src_q      <= src_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            deny_q     <= deny_d;
            a_ready_q  <= a_ready_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
            rdsel_q    <= rdsel_d;
        end
    end

    tl_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .re    (mem_re),
        .we    (mem_we),
        .addr  (idx_q),
        .wmask (mask_q),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    assign bus.a_ready  = a_ready_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_denied = d_denied_q;
    // The read register holds still for the whole response; only Get
    // responses expose it, everything else returns zero.
    assign bus.d_data   = rdsel_q ? mem_rdata : 64'd0;

endmodule

// File: tb/tb_tl_mem_responder.sv
// tb/tb_tl_mem_responder.sv - directed vector bench for tl_mem_responder (LATENCY 1 and 4)

module tb_tl_mem_responder;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_BAD  = 3'd2;
    localparam logic [2:0] ACK     = 3'd0;
    localparam logic [2:0] ACKD    = 3'd1;

    logic clk;
    logic rst;

    logic        av   [2];
    logic [2:0]  aop  [2];
    logic [2:0]  asz  [2];
    logic [3:0]  asrc [2];
    logic [7:0]  amsk [2];
    logic [63:0] aadr [2];
    logic [63:0] adat [2];
    logic        dr   [2];
    logic        ar   [2];
    logic        dv   [2];
    logic [2:0]  dop  [2];
    logic [2:0]  dsz  [2];
    logic [3:0]  dsrc [2];
    logic [63:0] ddat [2];
    logic        dden [2];

    tilelink tl0 ();
    tilelink tl1 ();

    assign tl0.a_valid = av[0];   assign tl1.a_valid = av[1];
    assign tl0.a_opcode = aop[0]; assign tl1.a_opcode = aop[1];
    assign tl0.a_size = asz[0];   assign tl1.a_size = asz[1];
    assign tl0.a_source = asrc[0]; assign tl1.a_source = asrc[1];
    assign tl0.a_mask = amsk[0];  assign tl1.a_mask = amsk[1];
    assign tl0.a_address = aadr[0]; assign tl1.a_address = aadr[1];
    assign tl0.a_data = adat[0];  assign tl1.a_data = adat[1];
    assign tl0.d_ready = dr[0];   assign tl1.d_ready = dr[1];
    assign ar[0] = tl0.a_ready;   assign ar[1] = tl1.a_ready;
    assign dv[0] = tl0.d_valid;   assign dv[1] = tl1.d_valid;
    assign dop[0] = tl0.d_opcode; assign dop[1] = tl1.d_opcode;
    assign dsz[0] = tl0.d_size;   assign dsz[1] = tl1.d_size;
    assign dsrc[0] = tl0.d_source; assign dsrc[1] = tl1.d_source;
    assign ddat[0] = tl0.d_data;  assign ddat[1] = tl1.d_data;
    assign dden[0] = tl0.d_denied; assign dden[1] = tl1.d_denied;

    tl_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(1)) dut0 (
        .clk (clk), .rst (rst), .bus (tl0)
    );

    tl_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(4)) dut1 (
        .clk (clk), .rst (rst), .bus (tl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          w;
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [3:0]  src;
        logic [7:0]  mask;
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  e_op;
        logic [63:0] e_data;
        logic        e_den;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int w, input logic [2:0] op, input logic [2:0] sz,
                       input logic [3:0] src, input logic [7:0] mask,
                       input logic [63:0] addr, input logic [63:0] data,
                       input logic [2:0] e_op, input logic [63:0] e_data,
                       input logic e_den, input int e_lat);
        vec_t v;
        v.w = w; v.op = op; v.sz = sz; v.src = src; v.mask = mask;
        v.addr = addr; v.data = data; v.e_op = e_op; v.e_data = e_data;
        v.e_den = e_den; v.e_lat = e_lat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request and returns 1 time unit after its acceptance edge.
    task automatic send_req(input int w, input logic [2:0] op, input logic [2:0] sz,
                            input logic [3:0] src, input logic [7:0] mask,
                            input logic [63:0] addr, input logic [63:0] data,
                            input bit hold, output bit ok);
        @(negedge clk);
        av[w] = 1'b1; aop[w] = op; asz[w] = sz; asrc[w] = src;
        amsk[w] = mask; aadr[w] = addr; adat[w] = data;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ar[w]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        if (!hold || !ok) av[w] = 1'b0;
    endtask

    task automatic wait_resp(input int w, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (dv[w]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic end_resp(input int w);
        dr[w] = 1'b1;
        @(posedge clk);
        #1;
        dr[w] = 1'b0;
    endtask

    bit ok;
    int n;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            av[w] = 1'b0; aop[w] = '0; asz[w] = '0; asrc[w] = '0;
            amsk[w] = '0; aadr[w] = '0; adat[w] = '0; dr[w] = 1'b0;
        end

        // Vector table
        add(0, OP_PUTF, 3, 4'h1, 8'hFF, 64'h8000_0010, 64'h1122334455667788, ACK, 64'd0, 1'b0, 1);
        add(0, OP_GET, 3, 4'h3, 8'hFF, 64'h8000_0010, 64'd0, ACKD, 64'h1122334455667788, 1'b0, 1);
        add(0, OP_PUTP, 3, 4'h2, 8'h0F, 64'h8000_0010, 64'hAAAAAAAA_BBBBBBBB, ACK, 64'd0, 1'b0, 1);
        add(0, OP_GET, 2, 4'h5, 8'h0F, 64'h8000_0013, 64'd0, ACKD, 64'h11223344_BBBBBBBB, 1'b0, 1);
        add(0, OP_BAD, 3, 4'h6, 8'hFF, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, ACK, 64'd0, 1'b1, 1);
        add(0, OP_GET, 3, 4'hA, 8'hFF, 64'h8000_0010, 64'd0, ACKD, 64'h11223344_BBBBBBBB, 1'b0, 1);
        add(0, OP_PUTF, 3, 4'h1, 8'hFF, 64'h8000_1FF8, 64'hDEADBEEF_CAFEF00D, ACK, 64'd0, 1'b0, 1);
`ifdef TL_MEM_DENY_EN
        add(0, OP_GET, 3, 4'h4, 8'hFF, 64'h7FFF_FFF8, 64'd0, ACKD, 64'd0, 1'b1, 1);
        add(0, OP_PUTF, 3, 4'h4, 8'hFF, 64'h8000_2000, 64'h0102030405060708, ACK, 64'd0, 1'b1, 1);
        add(0, OP_GET, 3, 4'h4, 8'hFF, 64'h8000_2000, 64'd0, ACKD, 64'd0, 1'b1, 1);
`else
        add(0, OP_GET, 3, 4'h4, 8'hFF, 64'h7FFF_FFF8, 64'd0, ACKD, 64'hDEADBEEF_CAFEF00D, 1'b0, 1);
        add(0, OP_PUTF, 3, 4'h4, 8'hFF, 64'h8000_2000, 64'h0102030405060708, ACK, 64'd0, 1'b0, 1);
        add(0, OP_GET, 3, 4'h4, 8'hFF, 64'h8000_0000, 64'd0, ACKD, 64'h0102030405060708, 1'b0, 1);
`endif
        add(1, OP_PUTF, 3, 4'h1, 8'hFF, 64'h8000_0000, 64'hA0A1A2A3_A4A5A6A7, ACK, 64'd0, 1'b0, 4);
        add(1, OP_PUTF, 3, 4'h1, 8'hFF, 64'h8000_0008, 64'hB0B1B2B3_B4B5B6B7, ACK, 64'd0, 1'b0, 4);
        add(1, OP_GET, 3, 4'h7, 8'hFF, 64'h8000_0000, 64'd0, ACKD, 64'hA0A1A2A3_A4A5A6A7, 1'b0, 4);
        add(1, OP_GET, 3, 4'h8, 8'hFF, 64'h8000_0008, 64'd0, ACKD, 64'hB0B1B2B3_B4B5B6B7, 1'b0, 4);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst a_ready", ar[0], 0);
        chk("rst d_valid", dv[0], 0);
        chk("rst d_opcode", dop[0], 0);
        chk("rst d_size", dsz[0], 0);
        chk("rst d_source", dsrc[0], 0);
        chk("rst d_data", ddat[0], 0);
        chk("rst d_denied", dden[0], 0);
        rst = 1'b0;
        #1;
        chk("a_ready before first edge", ar[0], 0);
        @(posedge clk);
        #1;
        chk("a_ready after first edge", ar[0], 1);
        chk("a_ready after first edge lat4", ar[1], 1);

        foreach (vecs[i]) begin
            send_req(vecs[i].w, vecs[i].op, vecs[i].sz, vecs[i].src, vecs[i].mask,
                     vecs[i].addr, vecs[i].data, 1'b0, ok);
            chk($sformatf("v%0d accepted", i), ok, 1);
            if (ok) begin
                chk($sformatf("v%0d a_ready low in WAIT", i), ar[vecs[i].w], 0);
                wait_resp(vecs[i].w, n, ok);
                chk($sformatf("v%0d d_valid seen", i), ok, 1);
                chk($sformatf("v%0d latency", i), n, vecs[i].e_lat);
                chk($sformatf("v%0d d_opcode", i), dop[vecs[i].w], vecs[i].e_op);
                chk($sformatf("v%0d d_data", i), ddat[vecs[i].w], vecs[i].e_data);
                chk($sformatf("v%0d d_denied", i), dden[vecs[i].w], vecs[i].e_den);
                chk($sformatf("v%0d d_source", i), dsrc[vecs[i].w], vecs[i].src);
                chk($sformatf("v%0d d_size", i), dsz[vecs[i].w], vecs[i].sz);
                end_resp(vecs[i].w);
                chk($sformatf("v%0d d_valid after D fire", i), dv[vecs[i].w], 0);
                chk($sformatf("v%0d a_ready after D fire", i), ar[vecs[i].w], 1);
            end
        end

        // Backpressure: d_ready low for 5 cycles, a_valid held high throughout
        send_req(0, OP_GET, 3, 4'h9, 8'hFF, 64'h8000_0010, 64'd0, 1'b1, ok);
        chk("stall accepted", ok, 1);
        wait_resp(0, n, ok);
        chk("stall d_valid seen", ok, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d d_valid", c), dv[0], 1);
            chk($sformatf("stall%0d d_data", c), ddat[0], 64'h11223344_BBBBBBBB);
            chk($sformatf("stall%0d d_opcode", c), dop[0], ACKD);
            chk($sformatf("stall%0d d_source", c), dsrc[0], 4'h9);
            chk($sformatf("stall%0d a_ready", c), ar[0], 0);
        end
        end_resp(0);
        av[0] = 1'b0;
        chk("stall d_valid dropped", dv[0], 0);
        chk("stall a_ready back", ar[0], 1);
        @(posedge clk);
        #1;
        chk("stall no re-accept", dv[0], 0);
        chk("stall a_ready held", ar[0], 1);

        // Reset in WAIT of a Put (LATENCY=4): write must not land
        send_req(1, OP_PUTF, 3, 4'h1, 8'hFF, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ok);
        chk("rstwait accepted", ok, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait d_valid", dv[1], 0);
        chk("rstwait a_ready", ar[1], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwait a_ready recovers", ar[1], 1);
        send_req(1, OP_GET, 3, 4'h2, 8'hFF, 64'h8000_0000, 64'd0, 1'b0, ok);
        chk("rstwait get accepted", ok, 1);
        wait_resp(1, n, ok);
        chk("rstwait get seen", ok, 1);
        chk("rstwait old word kept", ddat[1], 64'hA0A1A2A3_A4A5A6A7);
        end_resp(1);

        // Reset while a response is pending: d_valid drops without a clock edge
        send_req(0, OP_GET, 3, 4'h3, 8'hFF, 64'h8000_0010, 64'd0, 1'b0, ok);
        wait_resp(0, n, ok);
        chk("rstresp d_valid before", dv[0], 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstresp d_valid async", dv[0], 0);
        chk("rstresp d_data cleared", ddat[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
